decoder_64b66b: RTL and testbench
=================================

Name: decoder_64b66b

Overview:
- Receive-side 64B/66B decoder. It is the inverse of the PCS transmit encoder.
- Accepts one 66-bit block per valid/ready handshake from the descrambler/gearbox side.
- Emits the block as two 32-bit XGMII beats with 4-bit control: lanes 0-3 first, then lanes 4-7.
- Unrecognised blocks become error blocks, are counted, and are flagged.

Parameters:
- XGMII_DATA_WIDTH, 32, XGMII beat data width.
- XGMII_DATA_BYTES, XGMII_DATA_WIDTH/8, control bits per beat.
- PCS_DATA_WIDTH, 66, encoded block width.
- ERR_CNT_WIDTH, 16, width of the decode error counter.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous active-low reset.
- encoded_data_in  in  PCS_DATA_WIDTH  block: [65:64] sync, [63:56] type, [55:0] payload.
- encoded_valid_in  in  1  block valid.
- encoded_ready_out  out  1  decoder accepts block this cycle.
- xgmii_data_out  out  XGMII_DATA_WIDTH  beat data, lane n at [8n+7:8n].
- xgmii_ctrl_out  out  XGMII_DATA_BYTES  per-lane control flag.
- xgmii_valid_out  out  1  beat valid.
- xgmii_ready_in  in  1  downstream accepts beat.
- decode_error  out  1  one-cycle pulse for each invalid block decoded.
- error_count  out  ERR_CNT_WIDTH  saturating count of invalid blocks.

Behaviour:
- Reset (rst=0, asynchronous, any state):
  - State returns to EMPTY and any buffered block is discarded.
  - xgmii_valid_out=0, xgmii_data_out=32'h07070707, xgmii_ctrl_out=4'hF.
  - decode_error=0, error_count=0.
- Block acceptance:
  - A block is accepted when encoded_valid_in && encoded_ready_out.
  - encoded_ready_out = (state==EMPTY) || (state==HIGH && xgmii_ready_in). This is combinational.
- State machine:
  - EMPTY -> LOW on accept.
  - LOW -> HIGH when the low beat transfers (xgmii_valid_out && xgmii_ready_in).
  - HIGH -> LOW when the high beat transfers and a new block is accepted in the same cycle.
  - HIGH -> EMPTY when the high beat transfers and no block is accepted.
  - No state change while xgmii_ready_in=0. Beat data and control hold stable while valid and not ready.
- Throughput and latency:
  - Throughput is one block per 2 cycles with no bubble.
  - The low beat is valid in the cycle after accept.
- Decode: the 64-bit block D (lanes 0-7) and 8-bit control C are registered on accept.
  - sync 01: D=in[63:0], C=8'h00.
  - sync 10, type 1E: all lanes 07, C=FF.
  - sync 10, type 78 (S0): lane0=FB, lanes1-7 = in[55:0] (D[63:8]), C=01.
  - sync 10, type 33 (S4): lanes0-3=07, lane4=FB, lanes5-7 = in[23:0] (D[63:40]), C=1F.
  - sync 10, type 87 (T0): lane0=FD, lanes1-7=07, C=FF.
  - sync 10, types 99/AA/B4/CC/D2/E1/FF (Tn, n=1..7):
    - D[8n-1:0] = in[55:56-8n].
    - Lane n = FD; lanes above n = 07.
    - C bits n..7 = 1; bits below n = 0.
- Invalid blocks: sync 00 or 11, or sync 10 with any other type.
  - All lanes FE, C=FF.
  - decode_error pulses in the cycle the low beat first becomes valid.
  - error_count increments at that point and saturates at all-ones (no wrap).
- Output mapping: LOW beat = D[31:0]/C[3:0]; HIGH beat = D[63:32]/C[7:4].
- Outside valid beats, xgmii_data_out/xgmii_ctrl_out hold their last value. They carry no meaning while xgmii_valid_out=0.
- Asserting encoded_valid_in while encoded_ready_out=0 has no effect; upstream holds the block.

Test Plan:
- Reset then data block {01, 64'h0706050403020100} with ready_in=1.
  - Beats 32'h03020100/4'h0, then 32'h07060504/4'h0, on consecutive cycles.
  - Low beat is valid in the cycle after accept.
- S0 block {10, 78, 56'hDDCCBBAA998877}, then T3 block {10, B4, 24'h332211, 32'h0}.
  - Beat sequence: lane0=FB ctrl 1; next beat; then 32'h07FD2211 ctrl 4'hC? No — for T3 low beat use D[23:0] from in[55:32]: expect 32'hFD332211 with ctrl 4'h8, then 32'h07070707 with ctrl 4'hF.
- xgmii_ready_in=0 for 5 cycles mid-block.
  - Beat holds; encoded_ready_out=0 throughout; no beat dropped or duplicated.
- Continuous valid blocks with ready_in=1.
  - encoded_ready_out toggles; one block per 2 cycles; HIGH->LOW transition with no bubble.
- Sync 2'b11, then sync 10 type 8'h55.
  - Two FE/FF blocks; two decode_error pulses; error_count=2.
  - Force error_count to all-ones: it stays at all-ones.
- rst asserted asynchronously while in HIGH.
  - Outputs go to reset values immediately; the block is discarded.
  - After release, the first accepted block decodes correctly.

Source files
------------

// File: rtl/decoder_64b66b.sv
// Receive-side 64B/66B decoder: one 66-bit block per handshake in, two XGMII beats out
// (lanes 0-3, then lanes 4-7). Unrecognised blocks decode to error characters and are counted.
module decoder_64b66b #(
  parameter int XGMII_DATA_WIDTH = 32,
  parameter int XGMII_DATA_BYTES = XGMII_DATA_WIDTH / 8,
  parameter int PCS_DATA_WIDTH   = 66,
  parameter int ERR_CNT_WIDTH    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PCS_DATA_WIDTH-1:0]   encoded_data_in,
  input  logic                        encoded_valid_in,
  output logic                        encoded_ready_out,
  output logic [XGMII_DATA_WIDTH-1:0] xgmii_data_out,
  output logic [XGMII_DATA_BYTES-1:0] xgmii_ctrl_out,
  output logic                        xgmii_valid_out,
  input  logic                        xgmii_ready_in,
  output logic                        decode_error,
  output logic [ERR_CNT_WIDTH-1:0]    error_count
);

  localparam int BLK_W = 2 * XGMII_DATA_WIDTH;
  localparam int BLK_C = 2 * XGMII_DATA_BYTES;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  localparam logic [7:0] CH_IDLE  = 8'h07;
  localparam logic [7:0] CH_START = 8'hFB;
  localparam logic [7:0] CH_TERM  = 8'hFD;
  localparam logic [7:0] CH_ERR   = 8'hFE;

  localparam logic [7:0] BT_IDLE = 8'h1E;
  localparam logic [7:0] BT_S0   = 8'h78;
  localparam logic [7:0] BT_S4   = 8'h33;
  localparam logic [7:0] BT_T0   = 8'h87;
  localparam logic [7:0] BT_T1   = 8'h99;
  localparam logic [7:0] BT_T2   = 8'hAA;
  localparam logic [7:0] BT_T3   = 8'hB4;
  localparam logic [7:0] BT_T4   = 8'hCC;
  localparam logic [7:0] BT_T5   = 8'hD2;
  localparam logic [7:0] BT_T6   = 8'hE1;
  localparam logic [7:0] BT_T7   = 8'hFF;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_LOW,
    ST_HIGH
  } state_t;

  state_t                      state_q;
  logic [XGMII_DATA_WIDTH-1:0] data_q;
  logic [XGMII_DATA_BYTES-1:0] ctrl_q;
  logic [XGMII_DATA_WIDTH-1:0] hi_data_q;
  logic [XGMII_DATA_BYTES-1:0] hi_ctrl_q;
  logic                        valid_q;
  logic                        err_q;
  logic [ERR_CNT_WIDTH-1:0]    err_cnt_q;

  logic [BLK_W-1:0] blk_data_d;
  logic [BLK_C-1:0] blk_ctrl_d;
  logic             blk_bad_d;
  logic [63:0]      term_payload;
  int               term_lane;
  logic [1:0]       sync;
  logic [7:0]       btype;
  logic             accept;

  assign sync   = encoded_data_in[65:64];
  assign btype  = encoded_data_in[63:56];

  // The high beat's slot frees up in the same cycle it transfers, so a new block can follow back-to-back.
  assign encoded_ready_out = (state_q == ST_EMPTY) || ((state_q == ST_HIGH) && xgmii_ready_in);
  assign accept            = encoded_valid_in && encoded_ready_out;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through the case can infer a latch.
    blk_data_d   = {BLK_C{CH_ERR}};
    blk_ctrl_d   = '1;
    blk_bad_d    = 1'b1;
    term_lane    = BLK_C;
    term_payload = '0;

    if (sync == SYNC_DATA) begin
      blk_data_d = encoded_data_in[63:0];
      blk_ctrl_d = '0;
      blk_bad_d  = 1'b0;
    end else if (sync == SYNC_CTRL) begin
      blk_bad_d = 1'b0;
      case (btype)
        BT_IDLE: begin
          blk_data_d = {BLK_C{CH_IDLE}};
          blk_ctrl_d = '1;
        end
        BT_S0: begin
          blk_data_d = {encoded_data_in[55:0], CH_START};
          blk_ctrl_d = 8'h01;
        end
        BT_S4: begin
          blk_data_d = {encoded_data_in[23:0], CH_START, {4{CH_IDLE}}};
          blk_ctrl_d = 8'h1F;
        end
        BT_T0:   term_lane = 0;
        BT_T1:   term_lane = 1;
        BT_T2:   term_lane = 2;
        BT_T3:   term_lane = 3;
        BT_T4:   term_lane = 4;
        BT_T5:   term_lane = 5;
        BT_T6:   term_lane = 6;
        BT_T7:   term_lane = 7;
        default: blk_bad_d = 1'b1;
      endcase

      // Terminate with n data bytes: they sit left-justified in the payload, lane n is /T/, the rest idle.
      if (term_lane < BLK_C) begin
        term_payload = {8'h00, encoded_data_in[55:0]} >> (8 * (BLK_C - 1 - term_lane));
        for (int l = 0; l < BLK_C; l++) begin
          if (l < term_lane) begin
            blk_data_d[8*l +: 8] = term_payload[8*l +: 8];
            blk_ctrl_d[l]        = 1'b0;
          end else if (l == term_lane) begin
            blk_data_d[8*l +: 8] = CH_TERM;
            blk_ctrl_d[l]        = 1'b1;
          end else begin
            blk_data_d[8*l +: 8] = CH_IDLE;
            blk_ctrl_d[l]        = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_EMPTY;
      data_q    <= {XGMII_DATA_BYTES{CH_IDLE}};
      ctrl_q    <= '1;
      hi_data_q <= {XGMII_DATA_BYTES{CH_IDLE}};
      hi_ctrl_q <= '1;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here sees pre-edge values.
      err_q <= 1'b0;
      if (accept) begin
        state_q   <= ST_LOW;
        data_q    <= blk_data_d[XGMII_DATA_WIDTH-1:0];
        ctrl_q    <= blk_ctrl_d[XGMII_DATA_BYTES-1:0];
        hi_data_q <= blk_data_d[BLK_W-1:XGMII_DATA_WIDTH];
        hi_ctrl_q <= blk_ctrl_d[BLK_C-1:XGMII_DATA_BYTES];
        valid_q   <= 1'b1;
        err_q     <= blk_bad_d;
        if (blk_bad_d && (err_cnt_q != {ERR_CNT_WIDTH{1'b1}})) begin
          err_cnt_q <= err_cnt_q + ERR_CNT_WIDTH'(1);
        end
      end else begin
        case (state_q)
          ST_LOW: begin
            if (xgmii_ready_in) begin
              state_q <= ST_HIGH;
              data_q  <= hi_data_q;
              ctrl_q  <= hi_ctrl_q;
            end
          end
          ST_HIGH: begin
            if (xgmii_ready_in) begin
              state_q <= ST_EMPTY;
              valid_q <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign xgmii_data_out  = data_q;
  assign xgmii_ctrl_out  = ctrl_q;
  assign xgmii_valid_out = valid_q;
  assign decode_error    = err_q;
  assign error_count     = err_cnt_q;

endmodule

// File: tb/tb_decoder_64b66b.sv
// Scoreboard bench for decoder_64b66b: the driver queues hand-computed beats per block,
// a negedge monitor pops and compares every beat the DUT hands over.
module tb_decoder_64b66b;

  logic        clk = 1'b0;
  logic        rst;
  logic [65:0] encoded_data_in;
  logic        encoded_valid_in;
  logic        encoded_ready_out;
  logic [31:0] xgmii_data_out;
  logic [3:0]  xgmii_ctrl_out;
  logic        xgmii_valid_out;
  logic        xgmii_ready_in;
  logic        decode_error;
  logic [15:0] error_count;

  // Second instance with a 2-bit counter so saturation is reachable quickly.
  logic [65:0] s_data_in;
  logic        s_valid_in;
  logic        s_ready_out;
  logic [31:0] s_xdata;
  logic [3:0]  s_xctrl;
  logic        s_xvalid;
  logic        s_derr;
  logic [1:0]  s_cnt;

  decoder_64b66b u_dut (
    .clk               (clk),
    .rst               (rst),
    .encoded_data_in   (encoded_data_in),
    .encoded_valid_in  (encoded_valid_in),
    .encoded_ready_out (encoded_ready_out),
    .xgmii_data_out    (xgmii_data_out),
    .xgmii_ctrl_out    (xgmii_ctrl_out),
    .xgmii_valid_out   (xgmii_valid_out),
    .xgmii_ready_in    (xgmii_ready_in),
    .decode_error      (decode_error),
    .error_count       (error_count)
  );

  decoder_64b66b #(.ERR_CNT_WIDTH(2)) u_sat (
    .clk               (clk),
    .rst               (rst),
    .encoded_data_in   (s_data_in),
    .encoded_valid_in  (s_valid_in),
    .encoded_ready_out (s_ready_out),
    .xgmii_data_out    (s_xdata),
    .xgmii_ctrl_out    (s_xctrl),
    .xgmii_valid_out   (s_xvalid),
    .xgmii_ready_in    (1'b1),
    .decode_error      (s_derr),
    .error_count       (s_cnt)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  ctrl;
    bit          is_low;
    bit          err;
    int          id;
  } beat_t;

  beat_t exp_q[$];
  int    n_cmp    = 0;
  int    n_fail   = 0;
  int    n_pulses = 0;
  int    cyc      = 0;
  int    blk_id   = 0;
  bit    err_seen = 1'b0;

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: a beat transfers at the next posedge when valid && ready are both high here.
  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (decode_error) begin
          err_seen = 1'b1;
          n_pulses++;
        end
        if (xgmii_valid_out && xgmii_ready_in) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_beat: got %0h/%0h, expected none", xgmii_data_out, xgmii_ctrl_out);
          end else begin
            b = exp_q.pop_front();
            check($sformatf("blk%0d_%s_data", b.id, b.is_low ? "lo" : "hi"), xgmii_data_out, b.data);
            check($sformatf("blk%0d_%s_ctrl", b.id, b.is_low ? "lo" : "hi"), xgmii_ctrl_out, b.ctrl);
            if (b.is_low) begin
              check($sformatf("blk%0d_decode_error", b.id), err_seen, b.err);
              err_seen = 1'b0;
            end
          end
        end
      end
    end
  end

  // Leaves encoded_valid_in high on return (#1 after the accepting edge) so calls chain back-to-back.
  task automatic send_block(input logic [65:0] blk,
                            input logic [31:0] lo_d, input logic [3:0] lo_c,
                            input logic [31:0] hi_d, input logic [3:0] hi_c,
                            input bit bad, output int acc_cyc);
    int waited = 0;
    exp_q.push_back('{data: lo_d, ctrl: lo_c, is_low: 1'b1, err: bad, id: blk_id});
    exp_q.push_back('{data: hi_d, ctrl: hi_c, is_low: 1'b0, err: 1'b0, id: blk_id});
    encoded_data_in  = blk;
    encoded_valid_in = 1'b1;
    acc_cyc = -1;
    forever begin
      @(negedge clk);
      if (encoded_ready_out) break;
      waited++;
      if (waited > 64) begin
        n_cmp++;
        n_fail++;
        $display("FAIL blk%0d_accept_timeout: got no ready, expected ready within 64 cycles", blk_id);
        blk_id++;
        return;
      end
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    check($sformatf("blk%0d_latency_valid", blk_id), xgmii_valid_out, 1'b1);
    blk_id++;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    int a0, a1, prev;
    rst              = 1'b0;
    encoded_valid_in = 1'b0;
    encoded_data_in  = '0;
    xgmii_ready_in   = 1'b1;
    s_valid_in       = 1'b0;
    s_data_in        = {2'b11, 64'h0};

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", xgmii_valid_out, 1'b0);
    check("rst_data", xgmii_data_out, 32'h07070707);
    check("rst_ctrl", xgmii_ctrl_out, 4'hF);
    check("rst_derr", decode_error, 1'b0);
    check("rst_cnt", error_count, 16'd0);
    check("rst_ready", encoded_ready_out, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Data block, then S0 and T3 back-to-back.
    send_block({2'b01, 64'h0706050403020100}, 32'h03020100, 4'h0, 32'h07060504, 4'h0, 0, a0);
    send_block({2'b10, 8'h78, 56'hDDCCBBAA998877}, 32'h998877FB, 4'h1, 32'hDDCCBBAA, 4'h0, 0, a0);
    send_block({2'b10, 8'hB4, 24'h332211, 32'h0}, 32'hFD332211, 4'h8, 32'h07070707, 4'hF, 0, a0);
    send_block({2'b10, 8'h1E, 56'h0}, 32'h07070707, 4'hF, 32'h07070707, 4'hF, 0, a0);
    encoded_valid_in = 1'b0;
    wait_drain();

    // Downstream stall for 5 cycles while the T1 low beat is presented.
    send_block({2'b10, 8'h99, 8'h5A, 48'h0}, 32'h0707FD5A, 4'hE, 32'h07070707, 4'hF, 0, a0);
    encoded_valid_in = 1'b0;
    xgmii_ready_in   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("stall%0d_ready_out", i), encoded_ready_out, 1'b0);
      check($sformatf("stall%0d_valid", i), xgmii_valid_out, 1'b1);
      check($sformatf("stall%0d_data", i), {xgmii_ctrl_out, xgmii_data_out}, {4'hE, 32'h0707FD5A});
    end
    @(posedge clk);
    #1;
    xgmii_ready_in = 1'b1;

    // Continuous blocks: one accept every 2 cycles.
    send_block({2'b10, 8'h33, 32'h0, 24'hCCBBAA}, 32'h07070707, 4'hF, 32'hCCBBAAFB, 4'h1, 0, prev);
    send_block({2'b10, 8'h87, 56'h0}, 32'h070707FD, 4'hF, 32'h07070707, 4'hF, 0, a1);
    check("burst_gap1", a1 - prev, 2);
    prev = a1;
    send_block({2'b10, 8'hFF, 56'h66554433221100}, 32'h33221100, 4'h0, 32'hFD665544, 4'h8, 0, a1);
    check("burst_gap2", a1 - prev, 2);
    prev = a1;
    send_block({2'b10, 8'hD2, 40'hEEDDCCBBAA, 16'h0}, 32'hDDCCBBAA, 4'h0, 32'h0707FDEE, 4'hE, 0, a1);
    check("burst_gap3", a1 - prev, 2);
    prev = a1;
    send_block({2'b01, 64'hA7A6A5A4A3A2A1A0}, 32'hA3A2A1A0, 4'h0, 32'hA7A6A5A4, 4'h0, 0, a1);
    check("burst_gap4", a1 - prev, 2);
    encoded_valid_in = 1'b0;
    wait_drain();

    // Invalid blocks: bad sync, then unknown control type.
    send_block({2'b11, 64'h0123456789ABCDEF}, 32'hFEFEFEFE, 4'hF, 32'hFEFEFEFE, 4'hF, 1, a0);
    send_block({2'b10, 8'h55, 56'h0}, 32'hFEFEFEFE, 4'hF, 32'hFEFEFEFE, 4'hF, 1, a0);
    encoded_valid_in = 1'b0;
    wait_drain();
    repeat (2) @(posedge clk);
    #1;
    check("err_count_2", error_count, 16'd2);
    check("err_pulses_2", n_pulses, 2);

    // Asynchronous reset while the high beat is presented.
    send_block({2'b01, 64'h1122334455667788}, 32'h55667788, 4'h0, 32'h11223344, 4'h0, 0, a0);
    encoded_valid_in = 1'b0;
    @(posedge clk);
    #2;
    check("pre_rst_high_data", xgmii_data_out, 32'h11223344);
    rst = 1'b0;
    #1;
    check("async_rst_valid", xgmii_valid_out, 1'b0);
    check("async_rst_data", xgmii_data_out, 32'h07070707);
    check("async_rst_ctrl", xgmii_ctrl_out, 4'hF);
    check("async_rst_cnt", error_count, 16'd0);
    exp_q.delete();
    err_seen = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    send_block({2'b01, 64'hFFEEDDCCBBAA9988}, 32'hBBAA9988, 4'h0, 32'hFFEEDDCC, 4'h0, 0, a0);
    encoded_valid_in = 1'b0;
    wait_drain();
    check("post_rst_cnt", error_count, 16'd0);
    check("post_rst_pulses", n_pulses, 2);

    // Saturation on the 2-bit counter instance: 5 bad blocks must end at 3, not wrap.
    for (int i = 0; i < 5; i++) begin
      int waited = 0;
      s_valid_in = 1'b1;
      forever begin
        @(negedge clk);
        if (s_ready_out || waited > 64) break;
        waited++;
      end
      check($sformatf("sat%0d_ready", i), s_ready_out, 1'b1);
      @(posedge clk);
      #1;
      check($sformatf("sat%0d_cnt", i), s_cnt, (i < 2) ? i + 1 : 3);
    end
    s_valid_in = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("sat_final_cnt", s_cnt, 2'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test, expected finish before 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
